// File: rtl/ram32_arb_pkg.sv
// Shared constants and types for the RAM32 arbiter: macro geometry,
// FSM encodings and the per-port request bundle.
package ram32_arb_pkg;

  localparam int RAM32_AW    = 5;
  localparam int RAM32_DW    = 32;
  localparam int RAM32_BW    = 4;
  localparam int RAM32_DEPTH = 32;

  // Starvation counter width; covers STARVE_MAX up to 15.
  localparam int STARVE_W = 4;

  // FSM encodings
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One requester's access as presented to the macro mux.
  typedef struct packed {
    logic                we;
    logic [RAM32_BW-1:0] be;
    logic [RAM32_AW-1:0] addr;
    logic [RAM32_DW-1:0] wdata;
  } ram32_req_t;

  // Byte-write strobe seen by the macro: enables only on writes.
  function automatic logic [RAM32_BW-1:0] we_mask(input ram32_req_t req);
    return req.we ? req.be : '0;
  endfunction

endpackage

// File: rtl/ram32_arb_prio_pick.sv
// Two-way priority picker: A normally wins, but B is forced through after
// losing STARVE_MAX contended cycles in a row. Grants are combinational.
module ram32_prio_pick
  import ram32_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_force_b;
  logic                w_contend;

  assign w_contend = a_req & b_req;
  assign w_force_b = (r_starve_cnt == STARVE_W'(STARVE_MAX));

  assign b_gnt = en & b_req & (~a_req | w_force_b);
  assign a_gnt = en & a_req & ~(b_req & w_force_b);

  // Count consecutive contended losses of B; any B grant or idle B clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve_cnt <= '0;
    end else if (!b_req || b_gnt) begin
      r_starve_cnt <= '0;
    end else if (en && w_contend && a_gnt) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram32_arb.sv
// Arbiter and sequencer in front of the single-port 32x32 RAM32 macro.
// Port A has priority, port B is guarded against starvation, and a
// zero-fill sweep clears every word after reset or on init_start.
module ram32_arb
  import ram32_arb_pkg::*;
#(
  parameter int STARVE_MAX     = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                init_start,
  output logic                busy,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [RAM32_BW-1:0] a_be,
  input  logic [RAM32_AW-1:0] a_addr,
  input  logic [RAM32_DW-1:0] a_wdata,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [RAM32_DW-1:0] a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [RAM32_BW-1:0] b_be,
  input  logic [RAM32_AW-1:0] b_addr,
  input  logic [RAM32_DW-1:0] b_wdata,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [RAM32_DW-1:0] b_rdata,
  output logic                ram_en,
  output logic [RAM32_BW-1:0] ram_we,
  output logic [RAM32_AW-1:0] ram_a,
  output logic [RAM32_DW-1:0] ram_di,
  input  logic [RAM32_DW-1:0] ram_do
);

  logic [0:0]          r_state;
  logic [RAM32_AW-1:0] r_sweep_cnt;
  logic                r_a_rvalid;
  logic                r_b_rvalid;
  logic [RAM32_DW-1:0] r_a_hold;
  logic [RAM32_DW-1:0] r_b_hold;

  logic       w_run;
  logic       w_init;
  ram32_req_t w_a;
  ram32_req_t w_b;

  // Reset forces every macro pin and grant low in its own cycle.
  assign w_run  = (r_state == ST_RUN)  & ~RST;
  assign w_init = (r_state == ST_INIT) & ~RST;
  assign busy   = (r_state == ST_INIT);

  assign w_a = '{we: a_we, be: a_be, addr: a_addr, wdata: a_wdata};
  assign w_b = '{we: b_we, be: b_be, addr: b_addr, wdata: b_wdata};

  ram32_prio_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .CLK   (CLK),
    .RST   (RST),
    .en    (w_run),
    .a_req (a_req),
    .b_req (b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  // Macro pin mux: sweep writes zeros, otherwise the granted port drives.
  always_comb begin
    ram_en = 1'b0;
    ram_we = '0;
    ram_a  = '0;
    ram_di = '0;
    if (w_init) begin
      ram_en = 1'b1;
      ram_we = '1;
      ram_a  = r_sweep_cnt;
    end else if (a_gnt) begin
      ram_en = 1'b1;
      ram_we = we_mask(w_a);
      ram_a  = w_a.addr;
      ram_di = w_a.wdata;
    end else if (b_gnt) begin
      ram_en = 1'b1;
      ram_we = we_mask(w_b);
      ram_a  = w_b.addr;
      ram_di = w_b.wdata;
    end
  end

  // Sequencer: INIT walks 0..31 then hands over to RUN; init_start re-enters INIT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      r_sweep_cnt <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_sweep_cnt == RAM32_AW'(RAM32_DEPTH - 1)) begin
            r_state     <= ST_RUN;
            r_sweep_cnt <= '0;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
          end
        end
        default: begin
          if (init_start) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Read return: flag reads granted last cycle and keep the last returned word,
  // because the macro drives zero on Do0 whenever it is not enabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_hold   <= '0;
      r_b_hold   <= '0;
    end else begin
      r_a_rvalid <= a_gnt & ~a_we;
      r_b_rvalid <= b_gnt & ~b_we;
      if (r_a_rvalid) r_a_hold <= ram_do;
      if (r_b_rvalid) r_b_hold <= ram_do;
    end
  end

  assign a_rvalid = r_a_rvalid & ~RST;
  assign b_rvalid = r_b_rvalid & ~RST;
  assign a_rdata  = a_rvalid ? ram_do : r_a_hold;
  assign b_rdata  = b_rvalid ? ram_do : r_b_hold;

endmodule

// File: tb/tb_ram32_arb.sv
// Bench for ram32_arb: behavioural RAM32 macro, a cycle-level reference
// model of the arbiter's outputs, and directed scenarios with literal checks.
module tb_ram32_arb;

  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        init_start = 1'b0;
  logic        busy;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [3:0]  a_be = 4'h0;
  logic [4:0]  a_addr = 5'd0;
  logic [31:0] a_wdata = 32'h0;
  logic        a_gnt, a_rvalid;
  logic [31:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [3:0]  b_be = 4'h0;
  logic [4:0]  b_addr = 5'd0;
  logic [31:0] b_wdata = 32'h0;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [4:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do = 32'h0;

  int total = 0;
  int bad   = 0;

  ram32_arb #(.STARVE_MAX(SMAX), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RST(RST), .init_start(init_start), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 CLK = ~CLK;

  // RAM32 macro: registered read, byte writes, Do0 driven to zero when idle.
  logic [31:0] macro_mem [32];
  initial for (int i = 0; i < 32; i++) macro_mem[i] = 32'hDEADBEEF;
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= macro_mem[ram_a];
      for (int k = 0; k < 4; k++)
        if (ram_we[k]) macro_mem[ram_a][8*k +: 8] <= ram_di[8*k +: 8];
    end else begin
      ram_do <= 32'h0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: what the block must present each cycle, derived from
  // the contents the RAM should hold and the fairness rule for B.
  logic [31:0] m_mem [32];
  int          m_sweep_left = 0;
  int          m_b_losses   = 0;
  bit          m_known      = 0;
  bit          m_a_pend = 0, m_b_pend = 0;
  logic [31:0] m_a_pd = 0, m_b_pd = 0, m_a_hold = 0, m_b_hold = 0;

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'hDEADBEEF;
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("rst_a_gnt", 32'(a_gnt), 32'h0);
        chk("rst_b_gnt", 32'(b_gnt), 32'h0);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'h0);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_a", 32'(ram_a), 32'h0);
        chk("rst_ram_di", ram_di, 32'h0);
        if (m_known) begin
          chk("rst_a_rdata", a_rdata, m_a_hold);
          chk("rst_b_rdata", b_rdata, m_b_hold);
        end
        m_sweep_left = 32;
        m_b_losses = 0;
        m_a_pend = 0; m_b_pend = 0;
        m_a_hold = 0; m_b_hold = 0;
        m_known = 1;
      end else if (m_known) begin
        bit na_pend, nb_pend;
        na_pend = 0; nb_pend = 0;
        chk("m_a_rvalid", 32'(a_rvalid), 32'(m_a_pend));
        chk("m_b_rvalid", 32'(b_rvalid), 32'(m_b_pend));
        chk("m_a_rdata", a_rdata, m_a_pend ? m_a_pd : m_a_hold);
        chk("m_b_rdata", b_rdata, m_b_pend ? m_b_pd : m_b_hold);
        if (m_a_pend) m_a_hold = m_a_pd;
        if (m_b_pend) m_b_hold = m_b_pd;
        if (m_sweep_left > 0) begin
          int ad;
          ad = 32 - m_sweep_left;
          chk("m_busy", 32'(busy), 32'h1);
          chk("m_a_gnt", 32'(a_gnt), 32'h0);
          chk("m_b_gnt", 32'(b_gnt), 32'h0);
          chk("m_ram_en", 32'(ram_en), 32'h1);
          chk("m_ram_we", 32'(ram_we), 32'hF);
          chk("m_ram_a", 32'(ram_a), 32'(ad));
          chk("m_ram_di", ram_di, 32'h0);
          m_mem[ad] = 32'h0;
          m_sweep_left--;
          if (!b_req) m_b_losses = 0;
        end else begin
          bit b_wins, a_wins, w;
          logic [3:0]  be;
          logic [4:0]  ad;
          logic [31:0] wd;
          b_wins = b_req && (!a_req || m_b_losses == SMAX);
          a_wins = a_req && !b_wins;
          chk("m_busy", 32'(busy), 32'h0);
          chk("m_a_gnt", 32'(a_gnt), 32'(a_wins));
          chk("m_b_gnt", 32'(b_gnt), 32'(b_wins));
          w = a_wins ? a_we : b_we;
          be = a_wins ? a_be : b_be;
          ad = a_wins ? a_addr : b_addr;
          wd = a_wins ? a_wdata : b_wdata;
          if (a_wins || b_wins) begin
            chk("m_ram_en", 32'(ram_en), 32'h1);
            chk("m_ram_we", 32'(ram_we), w ? 32'(be) : 32'h0);
            chk("m_ram_a", 32'(ram_a), 32'(ad));
            chk("m_ram_di", ram_di, wd);
            if (w) begin
              for (int k = 0; k < 4; k++)
                if (be[k]) m_mem[ad][8*k +: 8] = wd[8*k +: 8];
            end else if (a_wins) begin
              na_pend = 1; m_a_pd = m_mem[ad];
            end else begin
              nb_pend = 1; m_b_pd = m_mem[ad];
            end
          end else begin
            chk("m_ram_en", 32'(ram_en), 32'h0);
            chk("m_ram_we", 32'(ram_we), 32'h0);
            chk("m_ram_a", 32'(ram_a), 32'h0);
            chk("m_ram_di", ram_di, 32'h0);
          end
          if (a_req && b_req && a_wins) m_b_losses++;
          else m_b_losses = 0;
          if (init_start) m_sweep_left = 32;
        end
        m_a_pend = na_pend;
        m_b_pend = nb_pend;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int    cnt;
    string pat;

    // Reset and power-up sweep
    tick(); tick();
    RST = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (busy) cnt++;
      tick();
    end
    chk("sweep_busy_cycles", 32'(cnt), 32'd32);

    // A reads every address after the sweep
    for (int i = 0; i < 32; i++) begin
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'(i);
      tick();
    end
    a_req = 1'b0;
    @(negedge CLK);
    chk("sweep_last_rvalid", 32'(a_rvalid), 32'h1);
    chk("sweep_last_rdata", a_rdata, 32'h0);
    tick();

    // Byte write and read-back
    a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 5'd5; a_wdata = 32'h11223344;
    tick();
    a_be = 4'b0010; a_wdata = 32'h0000AA00;
    tick();
    a_we = 1'b0;
    tick();
    a_req = 1'b0;
    @(negedge CLK);
    chk("bytewr_rvalid", 32'(a_rvalid), 32'h1);
    chk("bytewr_rdata", a_rdata, 32'h1122AA44);
    tick(); tick();
    @(negedge CLK);
    chk("bytewr_hold_rvalid", 32'(a_rvalid), 32'h0);
    chk("bytewr_hold_rdata", a_rdata, 32'h1122AA44);
    tick();

    // Continuous contention
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd31;
    pat = "";
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      pat = $sformatf("%s%s", pat, a_gnt ? "A" : (b_gnt ? "B" : "-"));
      tick();
    end
    total++;
    if (pat != "AAAABAAAABAAAAB") begin
      bad++;
      $display("FAIL grant_pattern actual=%s required=AAAABAAAABAAAAB", pat);
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // B write then immediate read of the same word
    b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 5'd31; b_wdata = 32'hCAFEF00D;
    tick();
    b_we = 1'b0;
    tick();
    b_req = 1'b0;
    @(negedge CLK);
    chk("wr_rd_b_rvalid", 32'(b_rvalid), 32'h1);
    chk("wr_rd_b_rdata", b_rdata, 32'hCAFEF00D);
    tick();

    // init_start together with an A read grant
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5; init_start = 1'b1;
    @(negedge CLK);
    chk("init_same_cycle_gnt", 32'(a_gnt), 32'h1);
    tick();
    init_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        chk("init_a_rvalid", 32'(a_rvalid), 32'h1);
        chk("init_a_rdata", a_rdata, 32'h1122AA44);
      end
      if (busy && !a_gnt && !b_gnt) cnt++;
      tick();
    end
    chk("init_quiet_cycles", 32'(cnt), 32'd32);
    @(negedge CLK);
    chk("first_gnt_after_sweep", 32'(a_gnt), 32'h1);
    tick();
    a_req = 1'b0;
    @(negedge CLK);
    chk("post_sweep_rdata", a_rdata, 32'h0);
    tick();

    // Reset in the cycle after a B read grant
    b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 5'd31; b_wdata = 32'h12345678;
    tick();
    b_we = 1'b0;
    tick();
    b_req = 1'b0; RST = 1'b1;
    @(negedge CLK);
    chk("rst_kills_b_rvalid", 32'(b_rvalid), 32'h0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_b_rdata_zero", b_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    repeat (34) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
